// File: rtl/ram_dp_pkg.sv
// Shared constants, FSM state type and the byte-lane merge helper for ram_dp_param.
package ram_dp_pkg;

   localparam int RD_OLD  = 0;
   localparam int RD_NEW  = 1;
   localparam int RD_HOLD = 2;

   // Upper bounds for the lane-merge helper; the top checks its parameters against them.
   localparam int MAX_DW = 256;
   localparam int MAX_BE = 32;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // A lane whose mask bit is 0 takes new_word; masked lanes keep old_word.
   function automatic logic [MAX_DW-1:0] merge_lanes(
      input logic [MAX_DW-1:0] old_word,
      input logic [MAX_DW-1:0] new_word,
      input logic [MAX_BE-1:0] mask,
      input int                lane_w,
      input int                be_w
   );
      logic [MAX_DW-1:0] res;
      int                lane;
      res = old_word;
      for (int j = 0; j < MAX_DW; j++) begin
         lane = j / lane_w;
         if ((lane < be_w) && (mask[lane] == 1'b0)) begin
            res[j] = new_word[j];
         end else begin
            res[j] = old_word[j];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_dp_clear_seq.sv
// Post-reset memory clear sequencer: walks every word once, then hands the RAM to the ports.
module ram_dp_clear_seq
   import ram_dp_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1 << ADDR_WIDTH,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  clr_we
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   cnt_r;
   logic                    busy_r;

   // Clear FSM: one zero write per cycle, BUSY drops on the edge that writes the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         if (CLEAR_ON_RST != 0) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
         end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
         end
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (cnt_r == LAST_ADDR) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + ADDR_WIDTH'(1);
               end
            end
            ST_IDLE: begin
               busy_r <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign clr_we   = busy_r;
   assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised single-clock true dual-port RAM with lane masks, port-A-wins collisions and reset clear.
// Optional RAM_OUTREG_EN adds a second output register on QA/QB/COLL (read latency 2).
module ram_dp_param
   import ram_dp_pkg::*;
#(
   parameter int DATA_WIDTH   = 18,
   parameter int BE_WIDTH     = 2,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1 << ADDR_WIDTH,
   parameter int READ_MODE    = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CENA,
   input  logic                  WENA,
   input  logic [BE_WIDTH-1:0]   WENBA,
   input  logic [ADDR_WIDTH-1:0] AA,
   input  logic [DATA_WIDTH-1:0] DA,
   output logic [DATA_WIDTH-1:0] QA,
   input  logic                  CENB,
   input  logic                  WENB,
   input  logic [BE_WIDTH-1:0]   WENBB,
   input  logic [ADDR_WIDTH-1:0] AB,
   input  logic [DATA_WIDTH-1:0] DB,
   output logic [DATA_WIDTH-1:0] QB,
   output logic                  BUSY,
   output logic                  COLL
);

   localparam int LANE_W = DATA_WIDTH / BE_WIDTH;

   generate
      if (((DATA_WIDTH % BE_WIDTH) != 0) || (READ_MODE > 2) || (READ_MODE < 0) ||
          (DATA_WIDTH > MAX_DW) || (BE_WIDTH > MAX_BE) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_param_err
         $error("ram_dp_param: illegal parameter combination");
      end
   endgenerate

   logic                  busy_s;
   logic                  clr_we_s;
   logic [ADDR_WIDTH-1:0] clr_addr_s;

   ram_dp_clear_seq #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DEPTH        (DEPTH),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear_seq (
      .clk      (CLK),
      .rst      (RST),
      .busy     (busy_s),
      .clr_addr (clr_addr_s),
      .clr_we   (clr_we_s)
   );

   assign BUSY = busy_s;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic a_in_s;
   logic b_in_s;

   generate
      if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full
         assign a_in_s = 1'b1;
         assign b_in_s = 1'b1;
      end else begin : g_partial
         assign a_in_s = (32'(AA) < 32'(DEPTH));
         assign b_in_s = (32'(AB) < 32'(DEPTH));
      end
   endgenerate

   logic                  acc_a_s, acc_b_s;
   logic                  wr_a_s, wr_b_s;
   logic                  coll_s;
   logic [DATA_WIDTH-1:0] old_a_s, old_b_s;
   logic [DATA_WIDTH-1:0] mrg_a_s, mrg_b_s, both_s;
   logic [DATA_WIDTH-1:0] new_a_s, new_b_s;

   // Access qualification, old-word fetch and lane merge; on a collision B fills only lanes A leaves masked.
   always_comb begin
      acc_a_s = !busy_s && !RST && !CENA;
      acc_b_s = !busy_s && !RST && !CENB;
      wr_a_s  = acc_a_s && !WENA && a_in_s;
      wr_b_s  = acc_b_s && !WENB && b_in_s;
      coll_s  = wr_a_s && wr_b_s && (AA == AB);
      old_a_s = a_in_s ? mem[AA] : '0;
      old_b_s = b_in_s ? mem[AB] : '0;
      mrg_a_s = DATA_WIDTH'(merge_lanes(MAX_DW'(old_a_s), MAX_DW'(DA), MAX_BE'(WENBA), LANE_W, BE_WIDTH));
      mrg_b_s = DATA_WIDTH'(merge_lanes(MAX_DW'(old_b_s), MAX_DW'(DB), MAX_BE'(WENBB), LANE_W, BE_WIDTH));
      both_s  = DATA_WIDTH'(merge_lanes(MAX_DW'(mrg_b_s), MAX_DW'(DA), MAX_BE'(WENBA), LANE_W, BE_WIDTH));
      if (coll_s) begin
         new_a_s = both_s;
         new_b_s = both_s;
      end else begin
         new_a_s = mrg_a_s;
         new_b_s = mrg_b_s;
      end
   end

   // Storage write: clear sequencer owns the array while busy, otherwise the two ports.
   always_ff @(posedge CLK) begin
      if (clr_we_s) begin
         mem[clr_addr_s] <= '0;
      end else begin
         if (wr_a_s) begin
            mem[AA] <= new_a_s;
         end
         if (wr_b_s && !coll_s) begin
            mem[AB] <= new_b_s;
         end
      end
   end

   logic [DATA_WIDTH-1:0] qa_r, qb_r;
   logic                  coll_r;

   // Port A first-stage read register with same-port read-during-write selection.
   always_ff @(posedge CLK) begin
      if (RST) begin
         qa_r <= '0;
      end else if (acc_a_s) begin
         if (!WENA) begin
            case (READ_MODE)
               RD_OLD:  qa_r <= old_a_s;
               RD_NEW:  qa_r <= a_in_s ? new_a_s : '0;
               RD_HOLD: qa_r <= qa_r;
               default: qa_r <= old_a_s;
            endcase
         end else begin
            qa_r <= old_a_s;
         end
      end
   end

   // Port B first-stage read register, same rules as port A.
   always_ff @(posedge CLK) begin
      if (RST) begin
         qb_r <= '0;
      end else if (acc_b_s) begin
         if (!WENB) begin
            case (READ_MODE)
               RD_OLD:  qb_r <= old_b_s;
               RD_NEW:  qb_r <= b_in_s ? new_b_s : '0;
               RD_HOLD: qb_r <= qb_r;
               default: qb_r <= old_b_s;
            endcase
         end else begin
            qb_r <= old_b_s;
         end
      end
   end

   // Collision pulse, aligned with the read data of the colliding cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         coll_r <= 1'b0;
      end else begin
         coll_r <= coll_s;
      end
   end

`ifdef RAM_OUTREG_EN
   logic [DATA_WIDTH-1:0] qa_o_r, qb_o_r;
   logic                  coll_o_r;

   // Second output stage: unconditional pipeline of Q and COLL.
   always_ff @(posedge CLK) begin
      if (RST) begin
         qa_o_r   <= '0;
         qb_o_r   <= '0;
         coll_o_r <= 1'b0;
      end else begin
         qa_o_r   <= qa_r;
         qb_o_r   <= qb_r;
         coll_o_r <= coll_r;
      end
   end

   assign QA   = qa_o_r;
   assign QB   = qb_o_r;
   assign COLL = coll_o_r;
`else
   assign QA   = qa_r;
   assign QB   = qb_r;
   assign COLL = coll_r;
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: three instances (READ_MODE 0/1/2) share one stimulus stream.
module tb_ram_dp_param;

`ifdef RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam int K_QA0 = 0, K_QB0 = 1, K_QA1 = 2, K_QB1 = 3, K_QA2 = 4, K_QB2 = 5, K_COLL0 = 6, K_BUSY0 = 7;

   logic        clk;
   logic        rst;
   logic        cena, wena, cenb, wenb;
   logic [1:0]  wenba, wenbb;
   logic [3:0]  aa, ab;
   logic [17:0] da, db;
   logic [17:0] qa0, qb0, qa1, qb1, qa2, qb2;
   logic        busy0, busy1, busy2, coll0, coll1, coll2;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int          due;
      int          kind;
      logic [17:0] exp;
      string       name;
   } item_t;

   item_t sb[$];

   ram_dp_param #(.DATA_WIDTH(18), .BE_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .READ_MODE(0), .CLEAR_ON_RST(1)) dut0 (
      .CLK(clk), .RST(rst),
      .CENA(cena), .WENA(wena), .WENBA(wenba), .AA(aa), .DA(da), .QA(qa0),
      .CENB(cenb), .WENB(wenb), .WENBB(wenbb), .AB(ab), .DB(db), .QB(qb0),
      .BUSY(busy0), .COLL(coll0));

   ram_dp_param #(.DATA_WIDTH(18), .BE_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .READ_MODE(1), .CLEAR_ON_RST(1)) dut1 (
      .CLK(clk), .RST(rst),
      .CENA(cena), .WENA(wena), .WENBA(wenba), .AA(aa), .DA(da), .QA(qa1),
      .CENB(cenb), .WENB(wenb), .WENBB(wenbb), .AB(ab), .DB(db), .QB(qb1),
      .BUSY(busy1), .COLL(coll1));

   ram_dp_param #(.DATA_WIDTH(18), .BE_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .READ_MODE(2), .CLEAR_ON_RST(1)) dut2 (
      .CLK(clk), .RST(rst),
      .CENA(cena), .WENA(wena), .WENBA(wenba), .AA(aa), .DA(da), .QA(qa2),
      .CENB(cenb), .WENB(wenb), .WENBB(wenbb), .AB(ab), .DB(db), .QB(qb2),
      .BUSY(busy2), .COLL(coll2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [17:0] actual(input int kind);
      case (kind)
         K_QA0:   return qa0;
         K_QB0:   return qb0;
         K_QA1:   return qa1;
         K_QB1:   return qb1;
         K_QA2:   return qa2;
         K_QB2:   return qb2;
         K_COLL0: return {17'd0, coll0};
         K_BUSY0: return {17'd0, busy0};
         default: return 18'h3FFFF;
      endcase
   endfunction

   // Monitor: compares and retires every scoreboard entry that falls due this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            n_checks++;
            if (actual(sb[i].kind) !== sb[i].exp) begin
               n_fail++;
               $display("FAIL %s: got %05h expected %05h (cycle %0d)", sb[i].name, actual(sb[i].kind), sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic expect_at(input int due, input int kind, input logic [17:0] exp, input string name);
      item_t it;
      it.due = due; it.kind = kind; it.exp = exp; it.name = name;
      sb.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cena = 1'b1; wena = 1'b1; wenba = 2'b00; aa = 4'd0; da = 18'd0;
      cenb = 1'b1; wenb = 1'b1; wenbb = 2'b00; ab = 4'd0; db = 18'd0;
   endtask

   task automatic drv_a(input logic wen, input logic [1:0] mask, input logic [3:0] addr, input logic [17:0] data);
      cena = 1'b0; wena = wen; wenba = mask; aa = addr; da = data;
   endtask

   task automatic drv_b(input logic wen, input logic [1:0] mask, input logic [3:0] addr, input logic [17:0] data);
      cenb = 1'b0; wenb = wen; wenbb = mask; ab = addr; db = data;
   endtask

   task automatic busy_window(input int start, input int n_high, input bit check_fall);
      for (int k = 0; k < n_high; k++) expect_at(start + k, K_BUSY0, 18'd1, "busy_high");
      if (check_fall) expect_at(start + 16, K_BUSY0, 18'd0, "busy_fall");
   endtask

   int r0;

   initial begin
      idle();
      rst = 1'b1;

      // 1: reset clear, writes during BUSY ignored, whole array reads back zero
      tick();
      r0 = cyc;
      rst = 1'b0;
      expect_at(r0, K_QA0, 18'd0, "reset_qa");
      expect_at(r0, K_QB0, 18'd0, "reset_qb");
      expect_at(r0, K_COLL0, 18'd0, "reset_coll");
      busy_window(r0, 16, 1'b1);
      for (int k = 0; k < 10; k++) begin
         drv_a(1'b0, 2'b00, 4'(k), 18'h15555);
         tick();
      end
      idle();
      while (cyc < r0 + 16) tick();
      for (int a = 0; a < 16; a++) begin
         drv_a(1'b1, 2'b00, 4'(a), 18'd0);
         expect_at(cyc + LAT, K_QA0, 18'd0, "clear_read");
         tick();
      end
      idle();

      // 2: lane mask
      drv_a(1'b0, 2'b00, 4'd3, 18'h3FFFF);
      tick();
      drv_a(1'b0, 2'b10, 4'd3, 18'h00000);
      expect_at(cyc + LAT, K_QA0, 18'h3FFFF, "rdw_old_mask");
      tick();
      drv_a(1'b1, 2'b00, 4'd3, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'h3FE00, "lane_mask");
      tick();
      idle();

      // 3: full collision, A wins
      drv_a(1'b0, 2'b00, 4'd5, 18'h00001);
      drv_b(1'b0, 2'b00, 4'd5, 18'h3FFFF);
      expect_at(cyc + LAT, K_COLL0, 18'd1, "coll_pulse");
      expect_at(cyc + LAT + 1, K_COLL0, 18'd0, "coll_end");
      expect_at(cyc + LAT, K_QB0, 18'd0, "coll_qb_old");
      tick();
      idle();
      drv_a(1'b1, 2'b00, 4'd5, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'h00001, "coll_a_wins");
      tick();
      idle();

      // 4: partial collision, B fills the lane A masks
      drv_a(1'b0, 2'b10, 4'd7, 18'h001FF);
      drv_b(1'b0, 2'b01, 4'd7, 18'h3FE00);
      expect_at(cyc + LAT, K_COLL0, 18'd1, "pcoll_pulse");
      tick();
      idle();
      drv_a(1'b1, 2'b00, 4'd7, 18'd0);
      drv_b(1'b1, 2'b00, 4'd7, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'h3FFFF, "pcoll_merge_a");
      expect_at(cyc + LAT, K_QB0, 18'h3FFFF, "pcoll_merge_b");
      expect_at(cyc + LAT, K_COLL0, 18'd0, "same_read_no_coll");
      tick();
      idle();

      // 5: read-during-write modes, cross-port read sees old word
      drv_a(1'b0, 2'b00, 4'd2, 18'h11111);
      tick();
      drv_a(1'b1, 2'b00, 4'd3, 18'd0);
      expect_at(cyc + LAT, K_QA2, 18'h3FE00, "hold_preload");
      tick();
      drv_a(1'b0, 2'b00, 4'd2, 18'h22222);
      drv_b(1'b1, 2'b00, 4'd2, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'h11111, "mode0_old");
      expect_at(cyc + LAT, K_QA1, 18'h22222, "mode1_new");
      expect_at(cyc + LAT, K_QA2, 18'h3FE00, "mode2_hold");
      expect_at(cyc + LAT, K_QB0, 18'h11111, "xport_old_m0");
      expect_at(cyc + LAT, K_QB1, 18'h11111, "xport_old_m1");
      expect_at(cyc + LAT, K_QB2, 18'h11111, "xport_old_m2");
      tick();
      idle();
      drv_a(1'b1, 2'b00, 4'd2, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'h22222, "mode_readback");
      expect_at(cyc + LAT, K_QA2, 18'h22222, "mode2_readback");
      tick();
      idle();

      // 6: reset during clear restarts the sequence
      rst = 1'b1;
      tick();
      r0 = cyc;
      rst = 1'b0;
      expect_at(r0, K_QA0, 18'd0, "rst2_qa");
      busy_window(r0, 5, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      r0 = cyc;
      rst = 1'b0;
      busy_window(r0, 16, 1'b1);
      while (cyc < r0 + 16) tick();
      drv_a(1'b1, 2'b00, 4'd2, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'd0, "reclear_2");
      tick();
      drv_a(1'b1, 2'b00, 4'd7, 18'd0);
      expect_at(cyc + LAT, K_QA0, 18'd0, "reclear_7");
      tick();
      idle();

      // drain with a bound; anything left over never came due
      for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
      while (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got nothing expected %05h (never compared)", sb[0].name, sb[0].exp);
         sb.delete(0);
      end

      tick();
      n_checks++;
      if (qa0 !== 18'd0) begin
         n_fail++;
         $display("FAIL final_qa0: got %05h expected 00000", qa0);
      end
      n_checks++;
      if (qa1 !== qa0) begin
         n_fail++;
         $display("FAIL final_qa1: got %05h expected %05h", qa1, qa0);
      end
      n_checks++;
      if (qa2 !== qa0) begin
         n_fail++;
         $display("FAIL final_qa2: got %05h expected %05h", qa2, qa0);
      end
      n_checks++;
      if (qb1 !== qb0) begin
         n_fail++;
         $display("FAIL final_qb1: got %05h expected %05h", qb1, qb0);
      end
      n_checks++;
      if (qb2 !== qb0) begin
         n_fail++;
         $display("FAIL final_qb2: got %05h expected %05h", qb2, qb0);
      end
      n_checks++;
      if (busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL final_busy: got %0b expected 0", busy0);
      end
      n_checks++;
      if (coll1 !== coll0) begin
         n_fail++;
         $display("FAIL final_coll: got %0b expected %0b", coll1, coll0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
